arb_mux_k: RTL and testbench
============================

# arb_mux_k

Registered, handshaked K-input arbitrating multiplexer: the sequential successor to our combinational K-to-1 mux. Instead of an external select, it grants one of K valid/ready input channels by round-robin or fixed priority. It holds the grant across multi-beat packets and presents the chosen beat on a one-deep registered output with its source index. It sits wherever several producers share one datapath, for example several PEs feeding one memory write port.

## Interface
- `K`, default 4: number of input channels; legal range 2..16.
- `SIZE`, default 16: data width per channel.
- `RR`, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, lowest index wins.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_bus` input, K*SIZE bits: flattened channel data; channel i occupies `in_bus[i*SIZE +: SIZE]`.
- `in_valid` input, K bits: channel i has a beat.
- `in_last` input, K bits: the beat on channel i ends its packet.
- `in_ready` output, K bits: beat on channel i is accepted this cycle; at most one bit is set (one-hot or zero).
- `out_data` output, SIZE bits: registered selected beat.
- `out_src` output, $clog2(K) bits: index of the channel that produced `out_data`.
- `out_last` output, 1 bit: registered copy of the accepted beat's last flag.
- `out_valid` output, 1 bit: output register holds a beat.
- `out_ready` input, 1 bit: downstream accepts the output beat.

## Operation
- Load enable: `load = !out_valid || out_ready`.
- Input transfer on channel i: `in_valid[i] && in_ready[i]`.
- Output transfer: `out_valid && out_ready`.
- Grant `g` is combinational and depends on lock state.
  - Unlocked, RR=1: first index with `in_valid` set, searching upward from `ptr` and wrapping K-1 to 0.
  - Unlocked, RR=0: lowest index with `in_valid` set.
  - Locked: `g = lock_src`, regardless of other valids.
- `in_ready[i] = load && (i == g) && in_valid[g]`. All bits are 0 while `rst_n` is low.
- Lock set: an accepted beat with `in_last=0` sets `locked=1` and `lock_src=g`.
- Lock clear: an accepted beat with `in_last=1` clears `locked`.
- Pointer: when a last beat is accepted from g, `ptr <= (g==K-1) ? 0 : g+1`. The pointer never moves mid-packet and never moves in RR=0.
- On acceptance, `out_data`, `out_src`, `out_last` load from channel g and `out_valid <= 1`.
- Output transfer with no new acceptance: `out_valid <= 0`; data registers hold their values.
- Simultaneous output transfer and acceptance: the register reloads and `out_valid` stays 1, giving full throughput of one beat per cycle.
- Locked while `in_valid[lock_src]=0`: no channel is granted; other channels wait. A stalled packet intentionally blocks the port.
- State machine has two states.
  - IDLE (`locked=0`) goes to PKT on a non-last acceptance.
  - PKT (`locked=1`) returns to IDLE on a last acceptance.
  - A single-beat packet (`last=1` on its first beat) stays in IDLE.
- Once `out_valid` is high, `out_data`, `out_src` and `out_last` are stable until the output transfer.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_src=0`, `out_last=0`, `ptr=0`, `locked=0`, `lock_src=0`, `in_ready=0`.
- Reset mid-packet discards the held beat and the lock.
- Latency: a beat accepted in cycle n is visible on the outputs in cycle n+1.
- Combinational paths:
  - `in_ready` depends combinationally on `in_valid`, `out_ready` and state.
  - No combinational path from `in_bus` or `in_last` to any output.
- Throughput: 1 beat/cycle with `out_ready` held high.
- Bubbles appear only when no valid channel is grantable.

## Structure
- Shared package `arb_pkg`:
  - Mode constants `ARB_FIXED=0` and `ARB_RR=1`.
  - Function `idx_w(K)` returning $clog2(K).
- Sub-module `rr_pick`, parameterised on K:
  - Inputs: request vector and base index.
  - Outputs: grant index and an any-request flag.
  - Implementation: rotate the request vector by base, find the lowest set bit, rotate the index back.
  - RR=0 instantiates it with base tied to 0.
- Top level contains the lock and pointer state, output register and handshake logic.

## Test plan
- K=4, RR=1, channels 0-3 valid continuously with single-beat packets, `out_ready=1` -> `out_src` sequence 0,1,2,3,0,...; one beat per cycle after the first.
- RR=0, channels 1 and 3 valid with single beats -> `out_src` stays 1 while channel 1 is valid; channel 3 is served only after `in_valid[1]` drops.
- Channel 2 sends a 3-beat packet (last on beat 3) while channel 0 is valid -> three consecutive `out_src=2` beats; then `ptr=3` and the next grant goes to channel 0, since 3 is idle and the search wraps.
- Lock stall: channel 1 mid-packet drops `in_valid` for 2 cycles while channel 2 is valid -> `in_ready=0000` for those cycles; the packet resumes on channel 1.
- Backpressure: `out_ready=0` for 3 cycles with `out_valid=1` -> `in_ready=0` throughout and `out_data` stable; on `out_ready=1`, simultaneous drain and reload occur in the same cycle.
- Assert `rst_n=0` mid-packet with `out_valid=1` -> all outputs go to their reset values immediately; after release, arbitration restarts from channel 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the arbitrating multiplexer: mode constants,
// the lock state encoding and the index-width helper.
package arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int k);
    return $clog2(k);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: returns the first requesting index at or above
// i_base, wrapping from K-1 back to 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int K  = 4,
  parameter int IW = idx_w(K)
) (
  input  logic [K-1:0]  i_req,
  input  logic [IW-1:0] i_base,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [2*K-1:0] w_dbl;
  logic [K-1:0]   w_rot;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;

  // rotate requests down by base, take the lowest set bit, rotate the index back
  always_comb begin
    w_dbl = {i_req, i_req} >> i_base;
    w_rot = w_dbl[K-1:0];
    w_off = {IW{1'b0}};
    for (int j = K - 1; j >= 0; j--) begin
      w_off = w_rot[j] ? IW'(j) : w_off;
    end
    w_sum = {1'b0, i_base} + {1'b0, w_off};
    o_any = |i_req;
    o_idx = (w_sum >= (IW+1)'(K)) ? IW'(w_sum - (IW+1)'(K)) : w_sum[IW-1:0];
  end

endmodule

// File: rtl/arb_mux_k.sv
// K-input arbitrating multiplexer with packet lock, round-robin or fixed
// priority grant, and a one-deep registered output stage.
module arb_mux_k
  import arb_pkg::*;
#(
  parameter int K    = 4,
  parameter int SIZE = 16,
  parameter int RR   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [K*SIZE-1:0]    in_bus,
  input  logic [K-1:0]         in_valid,
  input  logic [K-1:0]         in_last,
  output logic [K-1:0]         in_ready,
  output logic [SIZE-1:0]      out_data,
  output logic [$clog2(K)-1:0] out_src,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int IW = idx_w(K);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_lock_src;
  logic [IW-1:0] w_base;
  logic [IW-1:0] w_pick;
  logic          w_any;
  logic [IW-1:0] w_g;
  logic [IW-1:0] w_g_inc;
  logic          w_gv;
  logic          w_load;
  logic          w_acc;
  logic          w_acc_last;
  logic          w_acc_body;

  logic [SIZE-1:0] r_out_data;
  logic [IW-1:0]   r_out_src;
  logic            r_out_last;
  logic            r_out_valid;

  assign w_base = (RR == ARB_RR) ? r_ptr : {IW{1'b0}};

  rr_pick #(.K(K), .IW(IW)) u_pick (
    .i_req  (in_valid),
    .i_base (w_base),
    .o_idx  (w_pick),
    .o_any  (w_any)
  );

  // grant selection and input handshake; the lock overrides the picker
  always_comb begin
    w_load     = !r_out_valid || out_ready;
    w_g        = (r_state == ST_PKT) ? r_lock_src : w_pick;
    w_gv       = (r_state == ST_PKT) ? in_valid[r_lock_src] : w_any;
    w_acc      = rst_n && w_load && w_gv;
    w_acc_last = w_acc && in_last[w_g];
    w_acc_body = w_acc && !in_last[w_g];
    w_g_inc    = (w_g == IW'(K - 1)) ? {IW{1'b0}} : w_g + IW'(1);
    in_ready   = {K{1'b0}};
    if (w_acc) begin
      in_ready[w_g] = 1'b1;
    end else begin
      in_ready = {K{1'b0}};
    end
  end

  // packet lock next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = w_acc_body ? ST_PKT : ST_IDLE;
      ST_PKT:  w_state_nxt = w_acc_last ? ST_IDLE : ST_PKT;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // lock state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // lock owner and round-robin pointer; the pointer only moves on packet end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_src <= {IW{1'b0}};
      r_ptr      <= {IW{1'b0}};
    end else begin
      if (w_acc_body) begin
        r_lock_src <= w_g;
      end
      if (w_acc_last && (RR == ARB_RR)) begin
        r_ptr <= w_g_inc;
      end
    end
  end

  // output register: reload on acceptance, drain on transfer, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= {SIZE{1'b0}};
      r_out_src   <= {IW{1'b0}};
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_acc) begin
      r_out_data  <= in_bus[w_g*SIZE +: SIZE];
      r_out_src   <= w_g;
      r_out_last  <= in_last[w_g];
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_arb_mux_k.sv
// Bench for arb_mux_k: one round-robin and one fixed-priority instance share
// stimulus; a behavioural model and a directed vector table check both.
module tb_arb_mux_k;

  localparam int K    = 4;
  localparam int SIZE = 16;

  logic              clk;
  logic              rst_n;
  logic [K*SIZE-1:0] in_bus;
  logic [K-1:0]      in_valid;
  logic [K-1:0]      in_last;
  logic              out_ready;

  logic [K-1:0]    rdy_rr, rdy_fx;
  logic [SIZE-1:0] dat_rr, dat_fx;
  logic [1:0]      src_rr, src_fx;
  logic            lst_rr, lst_fx, ov_rr, ov_fx;

  arb_mux_k #(.K(K), .SIZE(SIZE), .RR(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy_rr), .out_data(dat_rr), .out_src(src_rr),
    .out_last(lst_rr), .out_valid(ov_rr), .out_ready(out_ready)
  );

  arb_mux_k #(.K(K), .SIZE(SIZE), .RR(0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy_fx), .out_data(dat_fx), .out_src(src_fx),
    .out_last(lst_fx), .out_valid(ov_fx), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  // model state, index 0 = fixed priority, 1 = round robin
  int              m_locked[2], m_lsrc[2], m_ptr[2], m_ov[2], m_os[2], m_ol[2];
  logic [SIZE-1:0] m_od[2];
  int              e_g[2];
  bit              e_acc[2];
  logic [K-1:0]    smp_rr, smp_fx;

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       o;
    logic [3:0] rrr;
    logic [3:0] rfx;
    logic       ov;
    logic [1:0] srr;
    logic [1:0] sfx;
  } vec_t;

  vec_t tbl[15];
  logic [SIZE-1:0] d1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_locked[m] = 0; m_lsrc[m] = 0; m_ptr[m] = 0;
      m_ov[m] = 0; m_os[m] = 0; m_ol[m] = 0; m_od[m] = '0;
    end
  endtask

  // who would be granted now: locked owner, else first valid from base upward
  task automatic model_pick();
    for (int m = 0; m < 2; m++) begin
      int base;
      bit found;
      int g;
      found = 0;
      g = 0;
      if (m_locked[m] != 0) begin
        g = m_lsrc[m];
        found = in_valid[g];
      end else begin
        base = (m == 1) ? m_ptr[m] : 0;
        for (int k = K - 1; k >= 0; k--) begin
          if (in_valid[(base + k) % K]) begin
            g = (base + k) % K;
            found = 1;
          end
        end
      end
      e_g[m]   = g;
      e_acc[m] = found && ((m_ov[m] == 0) || out_ready);
    end
  endtask

  task automatic model_commit();
    for (int m = 0; m < 2; m++) begin
      if (e_acc[m]) begin
        m_od[m] = in_bus[e_g[m]*SIZE +: SIZE];
        m_os[m] = e_g[m];
        m_ol[m] = in_last[e_g[m]];
        m_ov[m] = 1;
        if (in_last[e_g[m]]) begin
          m_locked[m] = 0;
          if (m == 1) m_ptr[m] = (e_g[m] + 1) % K;
        end else begin
          m_locked[m] = 1;
          m_lsrc[m] = e_g[m];
        end
      end else if (out_ready) begin
        m_ov[m] = 0;
      end
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic o);
    in_valid  = v;
    in_last   = l;
    out_ready = o;
    in_bus    = {$urandom(), $urandom()};
  endtask

  // one clock: ready checked mid-cycle, registered outputs checked after the edge
  task automatic cycle();
    logic [3:0] er;
    @(negedge clk);
    model_pick();
    smp_rr = rdy_rr;
    smp_fx = rdy_fx;
    er = e_acc[0] ? (4'b0001 << e_g[0]) : 4'b0000;
    chk("ready_fx", rdy_fx, er);
    er = e_acc[1] ? (4'b0001 << e_g[1]) : 4'b0000;
    chk("ready_rr", rdy_rr, er);
    @(posedge clk);
    model_commit();
    #1;
    chk("valid_fx", ov_fx, m_ov[0]);
    chk("valid_rr", ov_rr, m_ov[1]);
    chk("data_fx", dat_fx, m_od[0]);
    chk("data_rr", dat_rr, m_od[1]);
    chk("src_fx", src_fx, m_os[0]);
    chk("src_rr", src_rr, m_os[1]);
    chk("last_fx", lst_fx, m_ol[0]);
    chk("last_rr", lst_rr, m_ol[1]);
  endtask

  // asynchronous reset asserted between edges; outputs must clear at once
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ready_rr", rdy_rr, 4'b0000);
    chk("rst_ready_fx", rdy_fx, 4'b0000);
    chk("rst_out_rr", {ov_rr, lst_rr, src_rr, dat_rr}, 20'h0);
    chk("rst_out_fx", {ov_fx, lst_fx, src_fx, dat_fx}, 20'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1);
    do_reset();

    tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0, 2'd0};
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 4'b0001, 1'b1, 2'd1, 2'd0};
    tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 4'b0001, 1'b1, 2'd2, 2'd0};
    tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 4'b0001, 1'b1, 2'd3, 2'd0};
    tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0, 2'd0};
    tbl[5]  = '{4'b1010, 4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1, 2'd1};
    tbl[6]  = '{4'b1010, 4'b1111, 1'b1, 4'b1000, 4'b0010, 1'b1, 2'd3, 2'd1};
    tbl[7]  = '{4'b1000, 4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1, 2'd3, 2'd3};
    tbl[8]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd3, 2'd3};
    tbl[9]  = '{4'b0010, 4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 2'd1, 2'd1};
    tbl[10] = '{4'b0101, 4'b0001, 1'b1, 4'b0100, 4'b0001, 1'b1, 2'd2, 2'd0};
    tbl[11] = '{4'b0101, 4'b0001, 1'b1, 4'b0100, 4'b0001, 1'b1, 2'd2, 2'd0};
    tbl[12] = '{4'b0101, 4'b0101, 1'b1, 4'b0100, 4'b0001, 1'b1, 2'd2, 2'd0};
    tbl[13] = '{4'b0101, 4'b0101, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd0, 2'd0};
    tbl[14] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 2'd0};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].o);
      cycle();
      chk($sformatf("tbl%0d_ready_rr", i), smp_rr, tbl[i].rrr);
      chk($sformatf("tbl%0d_ready_fx", i), smp_fx, tbl[i].rfx);
      chk($sformatf("tbl%0d_valid_rr", i), ov_rr, tbl[i].ov);
      chk($sformatf("tbl%0d_valid_fx", i), ov_fx, tbl[i].ov);
      chk($sformatf("tbl%0d_src_rr", i), src_rr, tbl[i].srr);
      chk($sformatf("tbl%0d_src_fx", i), src_fx, tbl[i].sfx);
    end

    // lock stall: channel 1 mid-packet goes idle while channel 2 waits
    do_reset();
    drive(4'b0010, 4'b0000, 1'b1);
    cycle();
    for (int i = 0; i < 2; i++) begin
      drive(4'b0100, 4'b1111, 1'b1);
      cycle();
      chk("stall_ready_rr", smp_rr, 4'b0000);
      chk("stall_ready_fx", smp_fx, 4'b0000);
    end
    drive(4'b0110, 4'b0010, 1'b1);
    d1 = in_bus[1*SIZE +: SIZE];
    cycle();
    chk("resume_ready_rr", smp_rr, 4'b0010);
    chk("resume_ready_fx", smp_fx, 4'b0010);

    // backpressure: output held, nothing accepted, then drain and reload together
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, 4'b1111, 1'b0);
      cycle();
      chk("bp_ready_rr", smp_rr, 4'b0000);
      chk("bp_ready_fx", smp_fx, 4'b0000);
      chk("bp_data_rr", dat_rr, d1);
      chk("bp_data_fx", dat_fx, d1);
    end
    drive(4'b1111, 4'b1111, 1'b1);
    cycle();
    chk("drain_ready_rr", smp_rr, 4'b0100);
    chk("drain_ready_fx", smp_fx, 4'b0001);
    chk("drain_valid_rr", ov_rr, 1'b1);
    chk("drain_src_rr", src_rr, 2'd2);

    // reset in the middle of a packet with a beat held
    drive(4'b1000, 4'b0000, 1'b1);
    cycle();
    chk("pkt_src_rr", src_rr, 2'd3);
    drive(4'b1111, 4'b1111, 1'b1);
    do_reset();
    cycle();
    chk("post_rst_ready_rr", smp_rr, 4'b0001);
    chk("post_rst_ready_fx", smp_fx, 4'b0001);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
